// File: rtl/player_move_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | player_move_controller                                                   |
// | Turns direction buttons into move codes for the collision detector and  |
// | commits the detector's answer into the player position.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module player_move_controller #(
    parameter logic [4:0] SPAWN_X       = 5'd1,
    parameter logic [4:0] SPAWN_Y       = 5'd1,
    parameter int         GRID_W        = 20,
    parameter int         GRID_H        = 15,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         REPEAT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_left,
    input  logic       btn_down,
    input  logic [4:0] new_x_pos,
    input  logic [4:0] new_y_pos,
    output logic [2:0] move,
    output logic [4:0] current_x_pos,
    output logic [4:0] current_y_pos,
    output logic       moved,
    output logic       blocked
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RPT_W = $clog2(REPEAT_CYCLES);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST    = RPT_W'(REPEAT_CYCLES - 1);
    localparam logic [5:0]       GRID_W_L    = 6'(GRID_W);
    localparam logic [5:0]       GRID_H_L    = 6'(GRID_H);

    localparam logic [2:0] MOVE_NONE  = 3'b000;
    localparam logic [2:0] MOVE_RIGHT = 3'b100;
    localparam logic [2:0] MOVE_UP    = 3'b001;
    localparam logic [2:0] MOVE_LEFT  = 3'b010;
    localparam logic [2:0] MOVE_DOWN  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_COMMIT = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       btn_meta_q, btn_sync_q;
    logic [2:0]       move_q, move_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [4:0]       x_q, x_d, y_q, y_d;
    logic             moved_q, moved_d, blocked_q, blocked_d;

    logic [2:0]       prio_code;
    logic             any_pressed;
    logic             in_bounds;

    // Bit order {down, left, up, right}; two flops per button against metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 4'b0000;
            btn_sync_q <= 4'b0000;
        end else begin
            btn_meta_q <= {btn_down, btn_left, btn_up, btn_right};
            btn_sync_q <= btn_meta_q;
        end
    end

    always_comb begin
        prio_code = MOVE_NONE;
        if (btn_sync_q[0])      prio_code = MOVE_RIGHT;
        else if (btn_sync_q[1]) prio_code = MOVE_UP;
        else if (btn_sync_q[2]) prio_code = MOVE_LEFT;
        else if (btn_sync_q[3]) prio_code = MOVE_DOWN;
    end

    assign any_pressed = |btn_sync_q;
    assign in_bounds   = ({1'b0, new_x_pos} < GRID_W_L) && ({1'b0, new_y_pos} < GRID_H_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            move_q    <= MOVE_NONE;
            cnt_q     <= '0;
            rpt_q     <= '0;
            x_q       <= SPAWN_X;
            y_q       <= SPAWN_Y;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            move_q    <= move_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    // The code is latched on entry to ISSUE and only cleared on the way into HOLD,
    // so the detector sees one stable request followed by at least one idle cycle.
    always_comb begin
        state_d   = state_q;
        move_d    = move_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        x_d       = x_q;
        y_d       = y_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                move_d = MOVE_NONE;
                if (any_pressed) begin
                    state_d = ST_ISSUE;
                    move_d  = prio_code;
                end
            end
            ST_ISSUE: begin
                state_d = ST_SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_COMMIT: begin
                if (in_bounds) begin
                    x_d       = new_x_pos;
                    y_d       = new_y_pos;
                    moved_d   = (new_x_pos != x_q) || (new_y_pos != y_q);
                    blocked_d = (new_x_pos == x_q) && (new_y_pos == y_q);
                end else begin
                    blocked_d = 1'b1;
                end
                state_d = ST_HOLD;
                move_d  = MOVE_NONE;
                rpt_d   = '0;
            end
            ST_HOLD: begin
                move_d = MOVE_NONE;
                if (!any_pressed) begin
                    state_d = ST_IDLE;
                end else if (rpt_q == RPT_LAST) begin
                    state_d = ST_ISSUE;
                    move_d  = prio_code;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                move_d  = MOVE_NONE;
            end
        endcase
    end

    assign move          = move_q;
    assign current_x_pos = x_q;
    assign current_y_pos = y_q;
    assign moved         = moved_q;
    assign blocked       = blocked_q;

endmodule
`default_nettype wire

// File: tb/tb_player_move_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_player_move_controller                                                |
// | Self-checking bench with a behavioural collision detector model.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_player_move_controller;

    localparam int SETTLE = 2;
    localparam int REPEAT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_right = 1'b0, btn_up = 1'b0, btn_left = 1'b0, btn_down = 1'b0;
    logic [4:0] new_x_pos, new_y_pos;
    logic [2:0] move;
    logic [4:0] current_x_pos, current_y_pos;
    logic       moved, blocked;

    player_move_controller #(
        .SPAWN_X(5'd1), .SPAWN_Y(5'd1), .GRID_W(20), .GRID_H(15),
        .SETTLE_CYCLES(SETTLE), .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_right(btn_right), .btn_up(btn_up), .btn_left(btn_left), .btn_down(btn_down),
        .new_x_pos(new_x_pos), .new_y_pos(new_y_pos),
        .move(move), .current_x_pos(current_x_pos), .current_y_pos(current_y_pos),
        .moved(moved), .blocked(blocked)
    );

    always #5 clk = ~clk;

    // Detector model: 0 = arithmetic step, 1 = always blocked, 2 = fixed answer.
    int         mode = 0;
    logic [4:0] fx = 5'd0, fy = 5'd0;

    always_comb begin
        new_x_pos = current_x_pos;
        new_y_pos = current_y_pos;
        if (mode == 2 && move != 3'b000) begin
            new_x_pos = fx;
            new_y_pos = fy;
        end else if (mode == 0) begin
            case (move)
                3'b100:  new_x_pos = current_x_pos + 5'd1;
                3'b010:  new_x_pos = current_x_pos - 5'd1;
                3'b001:  new_y_pos = current_y_pos - 5'd1;
                3'b011:  new_y_pos = current_y_pos + 5'd1;
                default: new_x_pos = current_x_pos;
            endcase
        end
    end

    typedef struct {
        logic [2:0] code;
        logic [4:0] x;
        logic [4:0] y;
        logic       mv;
        logic       bl;
    } exp_t;

    typedef struct {
        logic [3:0] btn;   // {down, left, up, right}
        int         mode;
        logic [4:0] fx;
        logic [4:0] fy;
        logic [2:0] code;
        logic [4:0] ex;
        logic [4:0] ey;
        logic       mv;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[15];

    int tests = 0, fails = 0;
    int cyc = 0, commits = 0, issues = 0;
    int run_len = 0, last_issue = 0, prev_issue = 0;
    logic [2:0] prev_move = 3'b000, run_code = 3'b000;
    logic [1:0] prev_flags = 2'b00;

    task automatic check(input bit ok, input string name, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            run_len    = 0;
            prev_move  = 3'b000;
            prev_flags = 2'b00;
        end else begin
            if (move != 3'b000) begin
                if (prev_move == 3'b000) begin
                    issues++;
                    prev_issue = last_issue;
                    last_issue = cyc;
                    run_code   = move;
                end else begin
                    check(move == prev_move, "move_stable", move, prev_move);
                end
                run_len++;
            end else if (prev_move != 3'b000) begin
                check(run_len == SETTLE + 2, "move_length", run_len, SETTLE + 2);
                run_len = 0;
            end
            if (moved || blocked) begin
                commits++;
                check(prev_flags == 2'b00, "pulse_width", prev_flags, 0);
                if (sb.size() == 0) begin
                    check(0, "unexpected_commit", {moved, blocked}, 0);
                end else begin
                    e = sb.pop_front();
                    check(run_code == e.code, "move_code", run_code, e.code);
                    check(current_x_pos == e.x, "pos_x", current_x_pos, e.x);
                    check(current_y_pos == e.y, "pos_y", current_y_pos, e.y);
                    check({moved, blocked} == {e.mv, e.bl}, "moved_blocked",
                          {moved, blocked}, {e.mv, e.bl});
                end
            end
            prev_move  = move;
            prev_flags = {moved, blocked};
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn_down, btn_left, btn_up, btn_right} = b;
    endtask

    task automatic wait_commits(input int target, input int budget);
        int n = 0;
        while (commits < target && n < budget) begin
            tick();
            n++;
        end
        check(commits >= target, "commit_wait", commits, target);
    endtask

    task automatic wait_move(input int budget);
        int n = 0;
        while (move == 3'b000 && n < budget) begin
            tick();
            n++;
        end
        check(move != 3'b000, "move_wait", move, 1);
    endtask

    task automatic push_exp(input logic [2:0] c, input logic [4:0] x, input logic [4:0] y,
                            input logic mv);
        exp_t t;
        t.code = c; t.x = x; t.y = y; t.mv = mv; t.bl = !mv;
        sb.push_back(t);
    endtask

    int c0;

    initial begin
        vecs[0]  = '{4'b0010, 1, 5'd0,  5'd0,  3'b001, 5'd1,  5'd1,  1'b0};
        vecs[1]  = '{4'b0001, 0, 5'd0,  5'd0,  3'b100, 5'd2,  5'd1,  1'b1};
        vecs[2]  = '{4'b0100, 0, 5'd0,  5'd0,  3'b010, 5'd1,  5'd1,  1'b1};
        vecs[3]  = '{4'b0100, 0, 5'd0,  5'd0,  3'b010, 5'd0,  5'd1,  1'b1};
        vecs[4]  = '{4'b0100, 0, 5'd0,  5'd0,  3'b010, 5'd0,  5'd1,  1'b0};
        vecs[5]  = '{4'b1010, 0, 5'd0,  5'd0,  3'b001, 5'd0,  5'd0,  1'b1};
        vecs[6]  = '{4'b0010, 0, 5'd0,  5'd0,  3'b001, 5'd0,  5'd0,  1'b0};
        vecs[7]  = '{4'b1000, 0, 5'd0,  5'd0,  3'b011, 5'd0,  5'd1,  1'b1};
        vecs[8]  = '{4'b1111, 0, 5'd0,  5'd0,  3'b100, 5'd1,  5'd1,  1'b1};
        vecs[9]  = '{4'b1100, 0, 5'd0,  5'd0,  3'b010, 5'd0,  5'd1,  1'b1};
        vecs[10] = '{4'b0001, 2, 5'd19, 5'd14, 3'b100, 5'd19, 5'd14, 1'b1};
        vecs[11] = '{4'b1000, 2, 5'd20, 5'd14, 3'b011, 5'd19, 5'd14, 1'b0};
        vecs[12] = '{4'b1000, 2, 5'd19, 5'd15, 3'b011, 5'd19, 5'd14, 1'b0};
        vecs[13] = '{4'b0100, 2, 5'd19, 5'd14, 3'b010, 5'd19, 5'd14, 1'b0};
        vecs[14] = '{4'b0100, 0, 5'd0,  5'd0,  3'b010, 5'd18, 5'd14, 1'b1};

        repeat (3) tick();
        check(current_x_pos == 5'd1, "reset_x", current_x_pos, 1);
        check(current_y_pos == 5'd1, "reset_y", current_y_pos, 1);
        check(move == 3'b000, "reset_move", move, 0);
        check({moved, blocked} == 2'b00, "reset_flags", {moved, blocked}, 0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 15; i++) begin
            mode = vecs[i].mode;
            fx   = vecs[i].fx;
            fy   = vecs[i].fy;
            push_exp(vecs[i].code, vecs[i].ex, vecs[i].ey, vecs[i].mv);
            c0 = commits + 1;
            set_btns(vecs[i].btn);
            wait_commits(c0, 40);
            set_btns(4'b0000);
            repeat (6) tick();
        end

        // Reset in SETTLE aborts the command and reloads spawn.
        mode = 0;
        c0 = commits;
        set_btns(4'b0001);
        wait_move(20);
        tick();
        reset = 1'b1;
        set_btns(4'b0000);
        #1;
        check(current_x_pos == 5'd1, "abort_x", current_x_pos, 1);
        check(current_y_pos == 5'd1, "abort_y", current_y_pos, 1);
        check(move == 3'b000, "abort_move", move, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (15) tick();
        check(commits == c0, "abort_no_commit", commits, c0);

        // Button held across reset release acts as a fresh press.
        set_btns(4'b0001);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        push_exp(3'b100, 5'd2, 5'd1, 1'b1);
        reset = 1'b0;
        wait_commits(commits + 1, 40);
        set_btns(4'b0000);
        repeat (6) tick();

        // Auto-repeat while held.
        push_exp(3'b100, 5'd3, 5'd1, 1'b1);
        push_exp(3'b100, 5'd4, 5'd1, 1'b1);
        push_exp(3'b100, 5'd5, 5'd1, 1'b1);
        c0 = commits + 3;
        set_btns(4'b0001);
        wait_commits(c0, 100);
        set_btns(4'b0000);
        check(last_issue - prev_issue == SETTLE + 2 + REPEAT, "repeat_period",
              last_issue - prev_issue, SETTLE + 2 + REPEAT);
        repeat (8) tick();

        // Release while settling: commit still lands, no repeat follows.
        c0 = issues;
        push_exp(3'b001, 5'd5, 5'd0, 1'b1);
        set_btns(4'b0010);
        wait_move(20);
        set_btns(4'b0000);
        wait_commits(commits + 1, 40);
        repeat (30) tick();
        check(issues - c0 == 1, "no_repeat_after_release", issues - c0, 1);

        check(sb.size() == 0, "scoreboard_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
